// File: rtl/regfile_mp.sv
// Multi-port register file for the pipelined CPU: two prioritised write ports,
// optional write-to-read bypass, per-entry pending scoreboard and a registered debug port.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DBG_W-1:0]           dbg_data
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_next;
  logic [DBG_W-1:0]  dbg_q;
  logic              wr0_ok;
  logic              wr1_ok;

  // Port 1 wins a same-address collision, so port 0 is suppressed outright.
  assign wr1_ok = we1 && !(ZERO_EN && waddr1 == '0);
  assign wr0_ok = we0 && !(ZERO_EN && waddr0 == '0) && !(we1 && waddr1 == waddr0);

  always_comb begin
    pending_next = pending;
    if (we0) pending_next[waddr0] = 1'b0;
    if (we1) pending_next[waddr1] = 1'b0;
    if (issue_valid) pending_next[issue_addr] = 1'b1;
    if (ZERO_EN) pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pending <= '0;
      dbg_q   <= '0;
    end else begin
      if (wr0_ok) mem[waddr0] <= wdata0;
      if (wr1_ok) mem[waddr1] <= wdata1;
      pending <= pending_next;
      if (ZERO_EN && dbg_addr == '0) dbg_q <= '0;
      else                           dbg_q <= mem[dbg_addr][DBG_W-1:0];
    end
  end

  assign dbg_data = dbg_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    // Zero-register check comes last so it overrides any forwarded write.
    always_comb begin
      data = mem[addr];
      busy = pending[addr];
      if (BYP_EN) begin
        if (we1 && waddr1 == addr) begin
          data = wdata1;
          busy = 1'b0;
        end else if (we0 && waddr0 == addr) begin
          data = wdata0;
          busy = 1'b0;
        end
      end
      if (ZERO_EN && addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share
// stimulus; expectations are queued per step and checked against both.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        we0, we1, issue_valid;
  logic [4:0]  waddr0, waddr1, issue_addr, dbg_addr;
  logic [31:0] wdata0, wdata1;

  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [15:0] dbg_a, dbg_b;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  localparam int A_RD0 = 0, A_RD1 = 1, A_BUSY = 2, A_DBG = 3;
  localparam int B_RD0 = 4, B_BUSY = 5, B_DBG = 6;

  regfile_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] observe(int sel);
    case (sel)
      A_RD0:   return rd_data_a[31:0];
      A_RD1:   return rd_data_a[63:32];
      A_BUSY:  return {30'b0, rd_busy_a};
      A_DBG:   return {16'b0, dbg_a};
      B_RD0:   return rd_data_b[31:0];
      B_BUSY:  return {30'b0, rd_busy_b};
      B_DBG:   return {16'b0, dbg_b};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Step boundary: wait for the falling edge and drop all one-cycle controls.
  task automatic applyStimulus();
    @(negedge clk);
    reset       = 1'b0;
    we0         = 1'b0;
    we1         = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic setRd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic expectOut(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    rd_addr = '0;
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue_valid = 1'b0; issue_addr = '0;
    dbg_addr = 5'd5;

    // Fill every entry with all ones, then reset over the top of it.
    applyStimulus();
    for (int i = 0; i < 16; i++) begin
      applyStimulus();
      we0 = 1'b1; waddr0 = 5'(2*i);   wdata0 = 32'hFFFF_FFFF;
      we1 = 1'b1; waddr1 = 5'(2*i+1); wdata1 = 32'hFFFF_FFFF;
    end
    applyStimulus();
    setRd(5'd5, 5'd4);
    issue_valid = 1'b1; issue_addr = 5'd4;
    expectOut("pre_reset_r5", A_RD0, 32'hFFFF_FFFF);
    expectOut("pre_reset_dbg", A_DBG, 32'h0000_FFFF);
    checkOutput();

    applyStimulus();
    reset = 1'b1;
    expectOut("busy_before_reset", A_BUSY, 32'd2);
    checkOutput();

    applyStimulus();
    dbg_addr = 5'd0;
    expectOut("reset_rd0", A_RD0, 32'd0);
    expectOut("reset_rd1", A_RD1, 32'd0);
    expectOut("reset_busy_a", A_BUSY, 32'd0);
    expectOut("reset_busy_b", B_BUSY, 32'd0);
    expectOut("reset_dbg_a", A_DBG, 32'd0);
    expectOut("reset_dbg_b", B_DBG, 32'd0);
    checkOutput();

    // Write collision on r5.
    applyStimulus();
    setRd(5'd5, 5'd0);
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h77;
    expectOut("bypass_we0", A_RD0, 32'h77);
    expectOut("nobypass_we0", B_RD0, 32'h0);
    checkOutput();

    applyStimulus();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h2222;
    expectOut("collide_bypass", A_RD0, 32'h2222);
    expectOut("collide_old", B_RD0, 32'h77);
    checkOutput();

    applyStimulus();
    expectOut("collide_next_a", A_RD0, 32'h2222);
    expectOut("collide_next_b", B_RD0, 32'h2222);
    checkOutput();

    // Zero register ignores writes and issues.
    applyStimulus();
    setRd(5'd0, 5'd0);
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD;
    issue_valid = 1'b1; issue_addr = 5'd0;
    expectOut("zero_bypass", A_RD0, 32'd0);
    expectOut("zero_busy_now", A_BUSY, 32'd0);
    checkOutput();

    applyStimulus();
    expectOut("zero_rd_a", A_RD0, 32'd0);
    expectOut("zero_rd_b", B_RD0, 32'd0);
    expectOut("zero_busy_a", A_BUSY, 32'd0);
    expectOut("zero_busy_b", B_BUSY, 32'd0);
    expectOut("zero_dbg", A_DBG, 32'd0);
    checkOutput();

    // Scoreboard on r7.
    applyStimulus();
    setRd(5'd7, 5'd0);
    issue_valid = 1'b1; issue_addr = 5'd7;
    expectOut("issue_not_yet", A_BUSY, 32'd0);
    checkOutput();

    applyStimulus();
    expectOut("issue_busy_a", A_BUSY, 32'd1);
    expectOut("issue_busy_b", B_BUSY, 32'd1);
    checkOutput();

    applyStimulus();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h55;
    expectOut("wb_busy_a", A_BUSY, 32'd0);
    expectOut("wb_data_a", A_RD0, 32'h55);
    expectOut("wb_busy_b", B_BUSY, 32'd1);
    expectOut("wb_data_b", B_RD0, 32'h0);
    checkOutput();

    applyStimulus();
    issue_valid = 1'b1; issue_addr = 5'd7;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h66;
    expectOut("issue_wb_busy_a", A_BUSY, 32'd0);
    expectOut("issue_wb_data_a", A_RD0, 32'h66);
    expectOut("issue_wb_busy_b", B_BUSY, 32'd0);
    expectOut("issue_wb_data_b", B_RD0, 32'h55);
    checkOutput();

    applyStimulus();
    expectOut("issue_wins_a", A_BUSY, 32'd1);
    expectOut("issue_wins_b", B_BUSY, 32'd1);
    expectOut("issue_wins_data", A_RD0, 32'h66);
    checkOutput();

    // Two writes to different addresses both land.
    applyStimulus();
    setRd(5'd10, 5'd11);
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA1;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hB2;
    applyStimulus();
    expectOut("dual_rd0", A_RD0, 32'hA1);
    expectOut("dual_rd1", A_RD1, 32'hB2);
    expectOut("dual_rd0_b", B_RD0, 32'hA1);
    expectOut("dual_busy", A_BUSY, 32'd0);
    checkOutput();

    // Reset in the middle of pending work.
    applyStimulus();
    setRd(5'd3, 5'd9);
    issue_valid = 1'b1; issue_addr = 5'd3;
    applyStimulus();
    issue_valid = 1'b1; issue_addr = 5'd9;
    expectOut("mid_busy_r3", A_BUSY, 32'd1);
    checkOutput();

    applyStimulus();
    reset = 1'b1;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hCAFE;
    issue_valid = 1'b1; issue_addr = 5'd3;
    expectOut("mid_busy_a", A_BUSY, 32'd2);
    expectOut("mid_busy_b", B_BUSY, 32'd3);
    expectOut("mid_data_a", A_RD0, 32'hCAFE);
    checkOutput();

    applyStimulus();
    expectOut("post_busy_a", A_BUSY, 32'd0);
    expectOut("post_busy_b", B_BUSY, 32'd0);
    expectOut("post_r3_a", A_RD0, 32'd0);
    expectOut("post_r3_b", B_RD0, 32'd0);
    checkOutput();

    // Debug readout timing.
    applyStimulus();
    we1 = 1'b1; waddr1 = 5'd31; wdata1 = 32'hABCD_1234;
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h5678_9ABC;
    dbg_addr = 5'd31;
    applyStimulus();
    expectOut("dbg_prewrite_a", A_DBG, 32'd0);
    expectOut("dbg_prewrite_b", B_DBG, 32'd0);
    checkOutput();

    applyStimulus();
    dbg_addr = 5'd12;
    expectOut("dbg_r31", A_DBG, 32'h1234);
    expectOut("dbg_r31_b", B_DBG, 32'h1234);
    checkOutput();

    applyStimulus();
    expectOut("dbg_r12_a", A_DBG, 32'h9ABC);
    expectOut("dbg_r12_b", B_DBG, 32'h9ABC);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file, successor to the single-cycle CPU register file.
- For the pipelined CPU: configurable width, depth and read-port count; two write ports with fixed priority; optional write-to-read bypass.
- Per-register pending scoreboard for hazard detection; registered debug readout port replaces the fixed debug taps.
- Sits in the ID stage; WB drives the write ports, the issue logic drives the scoreboard.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 is hardwired zero.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.
- DBG_W, 16, width of the debug readout (must be <= DATA_W).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W], combinational.
- rd_busy  out  NUM_RD  port k's register has a pending write.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_W  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- waddr1  in  ADDR_W  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- issue_valid  in  1  mark a destination register pending.
- issue_addr  in  ADDR_W  destination register to mark.
- dbg_addr  in  ADDR_W  debug readout select.
- dbg_data  out  DBG_W  registered low DBG_W bits of the entry at dbg_addr.

Behaviour:
- Reset (synchronous, sampled on clk rising edge) clears:
  - all DEPTH entries to 0;
  - all pending bits to 0;
  - dbg_data to 0.
- Reset overrides every write and issue in the same cycle.
- Writes:
  - A write takes effect at the clock edge; the new value is readable from the next cycle.
  - we0 and we1 to the same address in the same cycle: wdata1 is stored, wdata0 is dropped.
  - Different addresses: both are stored.
- ZERO_REG=1:
  - entry 0 reads 0 on every port, including dbg_data;
  - writes to entry 0 are ignored;
  - issue to entry 0 is ignored, so pending[0] is always 0.
- ZERO_REG=0: entry 0 behaves as a normal register.
- Read with BYPASS=0: rd_data[k] = entry[rd_addr[k]], or 0 for entry 0 when ZERO_REG=1.
- Read with BYPASS=1:
  - If we1 && waddr1==rd_addr[k], return wdata1.
  - Otherwise, if we0 && waddr0==rd_addr[k], return wdata0.
  - Otherwise, return the stored value.
  - The zero-register rule takes precedence over bypass.
- Scoreboard, one pending bit per entry, evaluated at each clock edge:
  - A write (either port) to address a clears pending[a].
  - issue_valid sets pending[issue_addr].
  - Issue and write to the same address in the same cycle: issue wins, the bit ends up set (new producer in flight).
  - Issue to an already-pending register keeps it set; this is not an error.
- rd_busy[k]:
  - Base value: pending[rd_addr[k]] (registered state).
  - BYPASS=1: the bit is also forced 0 when a write to rd_addr[k] occurs in the same cycle, because the data is forwarded.
  - Issue in the same cycle does not affect rd_busy until the next cycle.
- Debug readout:
  - dbg_data is registered; it shows entry[dbg_addr][DBG_W-1:0] one cycle after dbg_addr is applied.
  - It samples the pre-write value: no bypass on the debug port.
- Width rules:
  - addresses are unsigned;
  - no range error is possible since DEPTH = 2**ADDR_W;
  - dbg_data takes bits [DBG_W-1:0] only.
- No other state; all outputs are fully defined in every cycle after reset.

Test Plan:
- Reset with all entries previously 32'hFFFFFFFF:
  - every rd_data reads 0, rd_busy is 0;
  - dbg_data = 0 on the cycle after reset.
- Write collision: we0=1, waddr0=5, wdata0=32'h1111 and we1=1, waddr1=5, wdata1=32'h2222 in the same cycle.
  - Same cycle, rd_addr port0=5: reads 32'h2222 with BYPASS=1, old value with BYPASS=0.
  - Next cycle: reads 32'h2222 for both settings.
- Zero register (ZERO_REG=1): write 32'hDEAD to entry 0 and issue entry 0.
  - rd_data for address 0 = 0, rd_busy = 0.
  - dbg_addr=0 gives dbg_data = 0.
- Scoreboard sequence:
  - issue r7, then next cycle rd_addr=7 gives rd_busy=1;
  - write r7 with 32'h55 gives rd_busy=0 in the same cycle (BYPASS=1) and rd_data=32'h55;
  - simultaneous issue r7 plus write r7 leaves rd_busy=1 the following cycle.
- Mid-operation reset: pending r3, r9 and write r3 in the same cycle as reset.
  - Next cycle: all pending bits 0, r3 = 0.
- Debug port: write r31 = 32'hABCD1234.
  - Next cycle, dbg_addr=31; the cycle after, dbg_data = 16'h1234.
  - Changing dbg_addr updates dbg_data exactly one cycle later.
